// File: rtl/conv_accumulator.sv
// 3x3 product-array window accumulator: sums nine signed lanes per beat, accumulates
// over a programmable channel count and emits one saturated output pixel per window.
module conv_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int CH_WIDTH   = 12,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                                 clk,
    input  logic                                 arst_n_in,
    input  logic signed [3*DATA_WIDTH-1:0]       product [0:2],
    input  logic                                 product_valid,
    output logic                                 product_ready,
    input  logic        [CH_WIDTH-1:0]           nb_channels,
    output logic signed [DATA_WIDTH-1:0]         out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy
);

    localparam int SUM_WIDTH = DATA_WIDTH + 4;

    // Clamp to DATA_WIDTH: in range exactly when all bits above the output sign agree.
    function automatic logic [DATA_WIDTH-1:0] sat_out(input logic [ACC_WIDTH-1:0] v);
        logic [ACC_WIDTH-DATA_WIDTH:0] top;
        top = v[ACC_WIDTH-1:DATA_WIDTH-1];
        if ((top == '0) || (top == '1)) begin
            sat_out = v[DATA_WIDTH-1:0];
        end else if (v[ACC_WIDTH-1]) begin
            sat_out = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_out = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    endfunction

    logic [CH_WIDTH-1:0]  in_cnt_r;
    logic [CH_WIDTH-1:0]  ch_total_r;
    logic [SUM_WIDTH-1:0] s1_sum_r;
    logic                 s1_last_r;
    logic                 s1_valid_r;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                 out_valid_r;

    logic                 en_s;
    logic                 accept_s;
    logic [CH_WIDTH-1:0]  ch_eff_s;
    logic                 last_s;
    logic [DATA_WIDTH-1:0] lane_s;
    logic [SUM_WIDTH-1:0] lane_sum_s;
    logic [ACC_WIDTH-1:0] total_s;

    // Handshake, window bookkeeping and the nine-lane adder tree.
    always_comb begin
        en_s     = !(out_valid_r && !out_ready);
        accept_s = product_valid && en_s;
        if (in_cnt_r == {CH_WIDTH{1'b0}}) begin
            ch_eff_s = (nb_channels == {CH_WIDTH{1'b0}}) ? {{(CH_WIDTH-1){1'b0}}, 1'b1} : nb_channels;
        end else begin
            ch_eff_s = ch_total_r;
        end
        last_s     = (in_cnt_r == (ch_eff_s - {{(CH_WIDTH-1){1'b0}}, 1'b1}));
        lane_s     = '0;
        lane_sum_s = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                lane_s     = product[ky][DATA_WIDTH*kx +: DATA_WIDTH];
                lane_sum_s = lane_sum_s + {{(SUM_WIDTH-DATA_WIDTH){lane_s[DATA_WIDTH-1]}}, lane_s};
            end
        end
        total_s = acc_r + {{(ACC_WIDTH-SUM_WIDTH){s1_sum_r[SUM_WIDTH-1]}}, s1_sum_r};
    end

    // Beat counter; channel count is captured only on the first beat of a window.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            in_cnt_r   <= '0;
            ch_total_r <= '0;
        end else if (accept_s) begin
            if (in_cnt_r == {CH_WIDTH{1'b0}}) begin
                ch_total_r <= ch_eff_s;
            end
            in_cnt_r <= last_s ? {CH_WIDTH{1'b0}} : in_cnt_r + {{(CH_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Stage 1: register the lane sum and its last-of-window flag.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            s1_sum_r   <= '0;
            s1_last_r  <= 1'b0;
            s1_valid_r <= 1'b0;
        end else if (accept_s) begin
            s1_sum_r   <= lane_sum_s;
            s1_last_r  <= last_s;
            s1_valid_r <= 1'b1;
        end else if (en_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: accumulate, and on the last beat publish the clamped pixel.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            acc_r       <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (en_s && s1_valid_r && s1_last_r) begin
            acc_r       <= '0;
            out_data_r  <= sat_out(total_s);
            out_valid_r <= 1'b1;
        end else begin
            if (en_s && s1_valid_r) begin
                acc_r <= total_s;
            end
            if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign product_ready = en_s;
    assign out_data      = out_data_r;
    assign out_valid     = out_valid_r;
    assign busy          = (in_cnt_r != {CH_WIDTH{1'b0}}) || s1_valid_r || out_valid_r;

endmodule

// File: tb/tb_conv_accumulator.sv
// Scoreboard bench for conv_accumulator: a bench-side window model pushes expected
// pixels on each accepted beat; a negedge monitor pops them on every output handshake.
module tb_conv_accumulator;

    logic               clk = 1'b0;
    logic               arst_n_in = 1'b0;
    logic signed [47:0] product [0:2];
    logic               product_valid = 1'b0;
    logic               product_ready;
    logic [11:0]        nb_channels = 12'd0;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic               busy;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    int m_cnt = 0;
    int m_tot = 0;
    longint m_acc = 0;

    conv_accumulator dut (
        .clk(clk), .arst_n_in(arst_n_in), .product(product),
        .product_valid(product_valid), .product_ready(product_ready),
        .nb_channels(nb_channels), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int lane_val(input int v);
        logic signed [15:0] l;
        l = v[15:0];
        return int'(l);
    endfunction

    // Drive one beat with all nine lanes = v; returns #1 after the accepting edge.
    task automatic send_beat(input int v, input int nch);
        logic [15:0] l;
        bit done;
        l = v[15:0];
        for (int r = 0; r < 3; r++) product[r] = {l, l, l};
        nb_channels   = nch[11:0];
        product_valid = 1'b1;
        done = 0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (product_ready) begin
                @(posedge clk);
                done = 1;
                if (m_cnt == 0) begin
                    m_tot = (nch == 0) ? 1 : nch;
                    m_acc = 0;
                end
                m_acc += 9 * lane_val(v);
                m_cnt++;
                if (m_cnt == m_tot) begin
                    exp_q.push_back(sat16(m_acc));
                    m_cnt = 0;
                end
                #1;
            end
        end
        if (!done) check_val("beat_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        product_valid = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check_val("drain_queue_empty", exp_q.size(), 0);
    endtask

    // Output monitor: compare each handshaked pixel against the scoreboard head.
    always @(negedge clk) begin
        if (arst_n_in && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_output", int'(out_data), 99999);
            end else begin
                check_val("out_data", int'(out_data), exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int r = 0; r < 3; r++) product[r] = '0;
        #12;
        check_val("reset_out_valid", int'(out_valid), 0);
        check_val("reset_busy", int'(busy), 0);
        arst_n_in = 1'b1;
        @(posedge clk); #1;
        check_val("reset_product_ready", int'(product_ready), 1);
        check_val("reset_out_data", int'(out_data), 0);

        // Single channel: result visible one edge after the edge following accept.
        send_beat(1, 1);
        product_valid = 1'b0;
        check_val("single_latency_early", int'(out_valid), 0);
        @(posedge clk); #1;
        check_val("single_valid", int'(out_valid), 1);
        check_val("single_data", int'(out_data), 9);
        @(posedge clk); #1;
        check_val("single_one_cycle", int'(out_valid), 0);

        // Multi-channel accumulation and saturation at both rails.
        for (int i = 0; i < 3; i++) send_beat(100, 3);
        for (int i = 0; i < 2; i++) send_beat(32'h7FFF, 2);
        send_beat(32'h8000, 1);
        drain();

        // Backpressure: result 18 held while the 27 beat waits in stage 1.
        out_ready = 1'b0;
        send_beat(2, 1);
        send_beat(3, 1);
        product_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall_ready_low", int'(product_ready), 0);
            check_val("stall_data_held", int'(out_data), 18);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // Zero channel count behaves as one.
        send_beat(4, 0);
        drain();

        // Asynchronous reset in the middle of a window.
        send_beat(50, 3);
        send_beat(50, 3);
        product_valid = 1'b0;
        arst_n_in = 1'b0;
        #2;
        check_val("midreset_out_valid", int'(out_valid), 0);
        check_val("midreset_busy", int'(busy), 0);
        m_cnt = 0;
        m_acc = 0;
        #1;
        arst_n_in = 1'b1;
        send_beat(2, 1);
        product_valid = 1'b0;
        @(posedge clk); #1;
        check_val("post_reset_data", int'(out_data), 18);
        drain();

        // Simultaneous pop and load: one window per cycle, output tracks input.
        for (int i = 0; i < 8; i++) begin
            send_beat(i * 1000 - 3000, 1);
            if (i >= 1) begin
                check_val("popload_valid", int'(out_valid), 1);
                check_val("popload_data", int'(out_data), sat16(9 * ((i - 1) * 1000 - 3000)));
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
